// File: rtl/ps2_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_pkg : receiver FSM encoding and PS/2 scan-code constants
// Rev 1.0
// ---------------------------------------------------------------------------
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int         DATA_BITS  = 8;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  // Odd parity: data ones plus the parity bit must total an odd count.
  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                         input logic                 parity);
    return ^{data, parity};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_clk_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_clk_filter : synchronises and debounces ps2_clk, emits fall_edge pulse
// Rev 1.0
// ---------------------------------------------------------------------------
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk_i,
  output logic fall_edge_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fall_q, fall_d;

  // The level only flips after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      cnt_q  <= '0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ps2_clk_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
      fall_q <= fall_d;
    end
  end

  assign fall_edge_o = fall_q;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ps2_keyboard_rx : PS/2 frame receiver delivering scan_code/prev_code pairs
// Rev 1.0
// ---------------------------------------------------------------------------
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic [7:0] prev_code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BCW = $clog2(DATA_BITS);

  logic                 fall_edge;
  logic [1:0]           data_sync_q;
  logic                 data_s;

  ps2_state_e           state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [7:0]           scan_q, scan_d, prev_q, prev_d;
  logic                 valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk_i   (ps2_clk),
    .fall_edge_o (fall_edge)
  );

  assign data_s = data_sync_q[1];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    scan_d    = scan_q;
    prev_d    = prev_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    if (state_q == IDLE || fall_edge) tmo_d = '0;
    else                              tmo_d = tmo_q + 1'b1;

    if (fall_edge) begin
      case (state_q)
        IDLE: begin
          if (!data_s) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {data_s, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_s;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          // A bad stop bit outranks a parity error.
          if (!data_s) begin
            ferr_d = 1'b1;
          end else if (odd_parity_ok(shift_q, parity_q)) begin
            prev_d  = scan_q;
            scan_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      tmo_d     = '0;
      ferr_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_sync_q <= 2'b11;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      scan_q      <= '0;
      prev_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      data_sync_q <= {data_sync_q[0], ps2_data};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      scan_q      <= scan_d;
      prev_q      <= prev_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign scan_code  = scan_q;
  assign prev_code  = prev_q;
  assign code_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ps2_keyboard_rx : scoreboard bench for the PS/2 keyboard receiver
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int FL   = 8;
  localparam int TMO  = 2000;
  localparam int HALF = 80;

  typedef struct {
    logic [2:0] kind;   // {code_valid, parity_err, frame_err}
    logic [7:0] scan;
    logic [7:0] prev;
  } exp_t;

  logic       clk, reset, ps2_clk, ps2_data;
  logic [7:0] scan_code, prev_code;
  logic       code_valid, parity_err, frame_err;

  exp_t       sb[$];
  logic [7:0] m_scan, m_prev;
  int         n_cmp, n_err;

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .prev_code  (prev_code),
    .code_valid (code_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  // Reference model: outcome of a whole frame from the protocol rules.
  task automatic expect_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    exp_t e;
    if (bad_stop)     e.kind = 3'b001;
    else if (bad_par) e.kind = 3'b010;
    else begin
      e.kind = 3'b100;
      m_prev = m_scan;
      m_scan = b;
    end
    e.scan = m_scan;
    e.prev = m_prev;
    sb.push_back(e);
  endtask

  task automatic expect_timeout();
    exp_t e;
    e.kind = 3'b001;
    e.scan = m_scan;
    e.prev = m_prev;
    sb.push_back(e);
  endtask

  function automatic logic [10:0] make_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~^b;
    if (bad_par) p = ~p;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  task automatic drive_bits(input logic [10:0] bits, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      if (glitch && i >= 1 && i <= 5) begin
        cyc(16);
        repeat (5) begin
          ps2_clk = 1'b0;
          cyc(FL - 2);
          ps2_clk = 1'b1;
          cyc(4);
        end
        cyc(HALF - 66);
      end else begin
        cyc(HALF);
      end
      ps2_clk = 1'b0;
      cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    cyc(2 * HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    expect_frame(b, bad_par, bad_stop);
    drive_bits(make_bits(b, bad_par, bad_stop), 11, glitch);
  endtask

  task automatic wait_drain(input int budget);
    int c;
    c = 0;
    while (sb.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d pending_events required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (code_valid || parity_err || frame_err)) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pulse got kind=%b scan=%h prev=%h required no pulse",
                   {code_valid, parity_err, frame_err}, scan_code, prev_code);
        end else begin
          e = sb.pop_front();
          if ({code_valid, parity_err, frame_err} !== e.kind ||
              scan_code !== e.scan || prev_code !== e.prev) begin
            n_err++;
            $display("FAIL event got kind=%b scan=%h prev=%h required kind=%b scan=%h prev=%h",
                     {code_valid, parity_err, frame_err}, scan_code, prev_code,
                     e.kind, e.scan, e.prev);
          end
        end
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_scan"},  scan_code, 8'h00);
    chk({tag, "_prev"},  prev_code, 8'h00);
    chk({tag, "_valid"}, {7'd0, code_valid}, 8'h00);
    chk({tag, "_perr"},  {7'd0, parity_err}, 8'h00);
    chk({tag, "_ferr"},  {7'd0, frame_err},  8'h00);
  endtask

  initial begin
    logic [10:0] bits;
    logic [7:0]  rb;
    int          r;

    n_cmp    = 0;
    n_err    = 0;
    m_scan   = 8'h00;
    m_prev   = 8'h00;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    reset    = 1'b1;
    fork
      monitor();
    join_none
    cyc(5);
    reset = 1'b0;
    cyc(1);
    check_zero_outputs("reset");
    cyc(20);

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(BREAK_CODE, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    send_frame(8'h33, 1'b1, 1'b1, 1'b0);
    wait_drain(HALF);

    // Truncated frame: start plus four data bits, then silence.
    expect_timeout();
    bits = make_bits(8'h75, 1'b0, 1'b0);
    drive_bits(bits, 5, 1'b0);
    cyc(TMO + 10);
    wait_drain(HALF);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);

    send_frame(8'h29, 1'b0, 1'b0, 1'b1);
    send_frame(EXT_CODE, 1'b0, 1'b0, 1'b0);
    wait_drain(HALF);

    // Reset after the fifth data bit discards the partial byte.
    bits = make_bits(8'h1C, 1'b0, 1'b0);
    drive_bits(bits, 6, 1'b0);
    reset = 1'b1;
    cyc(1);
    check_zero_outputs("midreset");
    reset  = 1'b0;
    m_scan = 8'h00;
    m_prev = 8'h00;
    cyc(20);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      r  = $urandom_range(0, 5);
      rb = 8'($urandom);
      if (r == 2) rb = BREAK_CODE;
      send_frame(rb, r == 0, r == 1, 1'b0);
    end

    wait_drain(4 * HALF);
    chk("final_scan", scan_code, m_scan);
    chk("final_prev", prev_code, m_prev);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
